// File: rtl/i2c_target.sv
// I2C target engine: synchronises raw SCL/SDA, detects START/STOP, matches ADDR, ACKs writes, serves reads.
// Optional build macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter on both lines.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       busy,
    output logic       rw,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       done_tick
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_DATA   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_DATA   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] scl_sync_r, sda_sync_r;
    logic       scl_s, sda_s;
    logic       scl_prev_r, sda_prev_r;
    state_t     state_r;
    logic [3:0] bit_cnt_r;
    logic [6:0] shift_r;
    logic [6:0] tx_sh_r;
    logic [7:0] byte_s;
    logic       scl_rise_s, scl_fall_s, start_s, stop_s;

    // Two-flop synchronisers; reset to the idle-bus level so release causes no false START.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_in};
            sda_sync_r <= {sda_sync_r[0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_win_r, sda_win_r;
    logic       scl_filt_r, sda_filt_r;

    // Majority over the current and two previous samples rejects single-clock pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_win_r  <= 2'b11;
            sda_win_r  <= 2'b11;
            scl_filt_r <= 1'b1;
            sda_filt_r <= 1'b1;
        end else begin
            scl_win_r  <= {scl_win_r[0], scl_sync_r[1]};
            sda_win_r  <= {sda_win_r[0], sda_sync_r[1]};
            scl_filt_r <= maj3(scl_sync_r[1], scl_win_r[0], scl_win_r[1]);
            sda_filt_r <= maj3(sda_sync_r[1], sda_win_r[0], sda_win_r[1]);
        end
    end

    assign scl_s = scl_filt_r;
    assign sda_s = sda_filt_r;
`else
    assign scl_s = scl_sync_r[1];
    assign sda_s = sda_sync_r[1];
`endif

    // One-sample history for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_prev_r <= scl_s;
            sda_prev_r <= sda_s;
        end
    end

    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    assign start_s    = scl_s & scl_prev_r & ~sda_s & sda_prev_r;
    assign stop_s     = scl_s & scl_prev_r & sda_s & ~sda_prev_r;
    assign byte_s     = {shift_r, sda_s};

    // Protocol FSM; START/STOP take priority over any SCL edge seen in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 7'd0;
            tx_sh_r   <= 7'd0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            rw        <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            done_tick <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            done_tick <= 1'b0;
            if (stop_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                done_tick <= busy;
            end else if (start_s) begin
                state_r   <= ST_ADDR;
                bit_cnt_r <= 4'd0;
                sda_oe    <= 1'b0;
                busy      <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r <= byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r <= 4'd8;
                                if (byte_s[7:1] == ADDR) begin
                                    rw      <= byte_s[0];
                                    state_r <= ST_ADDR_ACK;
                                end else begin
                                    state_r <= ST_WAIT_STOP;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    // bit_cnt 8 marks the fall that opens the ACK slot, 0 the one that closes it.
                    ST_ADDR_ACK: begin
                        if (scl_rise_s) begin
                            bit_cnt_r <= 4'd0;
                        end else if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe <= 1'b1;
                            end else if (rw) begin
                                tx_req  <= 1'b1;
                                tx_sh_r <= tx_data[6:0];
                                sda_oe  <= ~tx_data[7];
                                state_r <= ST_TX_DATA;
                            end else begin
                                sda_oe  <= 1'b0;
                                state_r <= ST_RX_DATA;
                            end
                        end
                    end
                    ST_RX_DATA: begin
                        if (scl_rise_s) begin
                            shift_r <= byte_s[6:0];
                            if (bit_cnt_r == 4'd7) begin
                                bit_cnt_r <= 4'd8;
                                rx_data   <= byte_s;
                                rx_valid  <= 1'b1;
                                state_r   <= ST_RX_ACK;
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 4'd1;
                            end
                        end
                    end
                    ST_RX_ACK: begin
                        if (scl_rise_s) begin
                            bit_cnt_r <= 4'd0;
                        end else if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                state_r <= ST_RX_DATA;
                            end
                        end
                    end
                    // tx_sh holds the bits still to be driven; bit 7 goes out when the byte is loaded.
                    ST_TX_DATA: begin
                        if (scl_rise_s) begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe  <= 1'b0;
                                state_r <= ST_TX_ACK;
                            end else begin
                                sda_oe  <= ~tx_sh_r[6];
                                tx_sh_r <= {tx_sh_r[5:0], 1'b0};
                            end
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise_s) begin
                            bit_cnt_r <= 4'd0;
                            if (sda_s) begin
                                state_r <= ST_WAIT_STOP;
                            end
                        end else if (scl_fall_s && (bit_cnt_r == 4'd0)) begin
                            tx_req  <= 1'b1;
                            tx_sh_r <= tx_data[6:0];
                            sda_oe  <= ~tx_data[7];
                            state_r <= ST_TX_DATA;
                        end
                    end
                    ST_WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        sda_oe  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: a bit-level I2C controller on a wired-AND SDA line,
// with expected results computed from byte-level transaction intent.
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scl_ctrl, sda_ctrl;
    logic       sda_line;
    logic       sda_oe, busy, rw, rx_valid, tx_req, done_tick;
    logic [7:0] rx_data, tx_data;

    int n_cmp = 0;
    int n_fail = 0;
    int rx_cnt = 0;
    int tx_cnt = 0;
    int done_cnt = 0;
    int oe_cnt = 0;

    logic [7:0] wr_q[$];
    logic [7:0] rd_q[$];

    assign sda_line = sda_ctrl & ~sda_oe;

    i2c_target #(.ADDR(7'h42)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .scl_in    (scl_ctrl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .rw        (rw),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .done_tick (done_tick)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_cnt++;
        if (tx_req === 1'b1) tx_cnt++;
        if (done_tick === 1'b1) done_cnt++;
        if (sda_oe === 1'b1) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One SCL period starting just after a fall; returns the line level seen mid-high.
    task automatic bus_bit(input logic b, input bit glitch, output logic s);
        tick(6);
        sda_ctrl = b;
        tick(1);
        if (glitch) scl_ctrl = 1'b1;
        tick(1);
        scl_ctrl = 1'b0;
        tick(2);
        scl_ctrl = 1'b1;
        tick(5);
        s = sda_line;
        tick(5);
        scl_ctrl = 1'b0;
    endtask

    task automatic do_start();
        tick(6);
        sda_ctrl = 1'b1;
        tick(4);
        scl_ctrl = 1'b1;
        tick(5);
        sda_ctrl = 1'b0;
        tick(5);
        scl_ctrl = 1'b0;
    endtask

    task automatic do_stop();
        tick(6);
        sda_ctrl = 1'b0;
        tick(4);
        scl_ctrl = 1'b1;
        tick(5);
        sda_ctrl = 1'b1;
        tick(10);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gpos, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(v[i], (i == gpos), s);
        bus_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_body();
        logic [7:0] v;
        logic s;
        for (int k = 0; k < rd_q.size(); k++) begin
            for (int i = 7; i >= 0; i--) begin
                bus_bit(1'b1, 1'b0, s);
                v[i] = s;
            end
            check("rd_byte", v, rd_q[k]);
            if (k < rd_q.size() - 1) begin
                tx_data = rd_q[k + 1];
                bus_bit(1'b0, 1'b0, s);
            end else begin
                bus_bit(1'b1, 1'b0, s);
            end
        end
        tick(4);
        check("rd_release_after_nack", sda_oe, 0);
    endtask

    // Write transaction of wr_q; gpos >= 0 injects a 1-clk SCL glitch in that bit of the first byte.
    task automatic write_txn(input int gpos);
        int rx0, dn0;
        logic a;
        logic [7:0] exp_last;
        logic bq[$];
        rx0 = rx_cnt;
        dn0 = done_cnt;
        do_start();
        check("wr_busy", busy, 1);
        send_byte(8'h84, -1, a);
        check("wr_addr_ack", a, 0);
        for (int k = 0; k < wr_q.size(); k++) begin
            send_byte(wr_q[k], (k == 0) ? gpos : -1, a);
            if (gpos < 0) check("wr_data_ack", a, 0);
        end
        do_stop();
        exp_last = wr_q[wr_q.size() - 1];
`ifndef I2C_TARGET_GLITCH_FILTER_EN
        if (gpos >= 0) begin
            for (int i = 7; i >= 0; i--) begin
                bq.push_back(wr_q[0][i]);
                if (i == gpos) bq.push_back(wr_q[0][i]);
            end
            for (int j = 0; j < 8; j++) exp_last[7 - j] = bq[j];
        end
`endif
        check("wr_rx_valid_count", rx_cnt - rx0, wr_q.size());
        check("wr_rx_data", rx_data, exp_last);
        check("wr_done_count", done_cnt - dn0, 1);
        check("wr_busy_after_stop", busy, 0);
    endtask

    task automatic read_txn();
        int tx0, dn0;
        logic a;
        tx0 = tx_cnt;
        dn0 = done_cnt;
        tx_data = rd_q[0];
        do_start();
        check("rd_busy", busy, 1);
        send_byte(8'h85, -1, a);
        check("rd_addr_ack", a, 0);
        read_body();
        do_stop();
        check("rd_tx_req_count", tx_cnt - tx0, rd_q.size());
        check("rd_rw", rw, 1);
        check("rd_busy_after_stop", busy, 0);
        check("rd_done_count", done_cnt - dn0, 1);
    endtask

    initial begin
        int rx0, tx0, dn0, oe0, n;
        logic a, s;
        bit seen;

        reset_n  = 1'b0;
        scl_ctrl = 1'b1;
        sda_ctrl = 1'b1;
        tx_data  = 8'h00;
        tick(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rw", rw, 0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_pulses", {rx_valid, tx_req, done_tick}, 3'b000);
        reset_n = 1'b1;
        tick(5);

        // Directed write: address 0x84 then 0xA5
        wr_q = '{8'hA5};
        write_txn(-1);

        // Directed read of 0x3C with controller NACK
        rd_q = '{8'h3C};
        read_txn();

        // Address miss (7'h43): bus never pulled, no data handshakes
        rx0 = rx_cnt; tx0 = tx_cnt; dn0 = done_cnt; oe0 = oe_cnt;
        do_start();
        send_byte(8'h86, -1, a);
        check("miss_nack", a, 1);
        send_byte(8'(($urandom)), -1, a);
        do_stop();
        check("miss_oe_cycles", oe_cnt - oe0, 0);
        check("miss_rx_valid", rx_cnt - rx0, 0);
        check("miss_tx_req", tx_cnt - tx0, 0);
        check("miss_busy", busy, 0);
        check("miss_done", done_cnt - dn0, 1);

        // Partial write byte interrupted by repeated START into a read
        rx0 = rx_cnt; tx0 = tx_cnt;
        do_start();
        send_byte(8'h84, -1, a);
        check("rs_addr_ack", a, 0);
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), 1'b0, s);
        rd_q = '{8'(($urandom))};
        tx_data = rd_q[0];
        do_start();
        send_byte(8'h85, -1, a);
        check("rs_addr2_ack", a, 0);
        check("rs_rw", rw, 1);
        read_body();
        do_stop();
        check("rs_no_rx_valid", rx_cnt - rx0, 0);
        check("rs_tx_req", tx_cnt - tx0, 1);

        // Reset asserted while the address ACK is being driven
        do_start();
        for (int i = 7; i >= 0; i--) bus_bit(logic'(8'h84 >> i), 1'b0, s);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (sda_oe === 1'b1) seen = 1'b1;
        end
        check("ack_oe_seen", seen, 1);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_sda_oe", sda_oe, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_rx_data", rx_data, 8'h00);
        check("rst_mid_rw", rw, 0);
        tick(3);
        reset_n = 1'b1;
        tick(2);
        do_stop();
        wr_q = '{8'(($urandom)), 8'(($urandom))};
        write_txn(-1);

        // Randomised write/read transactions
        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 3));
            wr_q.delete();
            for (int k = 0; k < n; k++) wr_q.push_back(8'($urandom));
            write_txn(-1);
            n = int'($urandom_range(1, 3));
            rd_q.delete();
            for (int k = 0; k < n; k++) rd_q.push_back(8'($urandom));
            read_txn();
        end

        // SCL glitch in bit 3 of a single write byte
        wr_q = '{8'hB6};
        write_txn(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
